// File: rtl/uart_pkg.sv
// Shared constants for the UART memory dump path: bit timing, frame length
// and the state encodings of the dump FSM and the byte transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int FRAME_BITS       = 10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_WAIT_RD = 3'd2;
  localparam logic [2:0] ST_SEND_LO = 3'd3;
  localparam logic [2:0] ST_SEND_HI = 3'd4;
  localparam logic [2:0] ST_NEXT    = 3'd5;
  localparam logic [2:0] ST_FINISH  = 3'd6;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start bit, D0..D7 LSB first, stop bit, each held
// CLKS_PER_BIT cycles. tx_done marks the last cycle of the stop bit.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    st;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk_100) begin
    if (rst) begin
      st       <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      case (st)
        TX_IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            st       <= TX_START;
            baud_cnt <= '0;
            tx       <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            st       <= TX_DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              st <= TX_STOP;
              tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            st       <= TX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Shift register is pure data: loaded on accept, shifted at each data-bit boundary.
  always_ff @(posedge clk_100) begin
    if (st == TX_IDLE && tx_start)
      shreg <= tx_data;
    else if (st == TX_DATA && baud_cnt == BIT_LAST)
      shreg <= {1'b0, shreg[7:1]};
  end

  assign tx_busy = (st != TX_IDLE);
  assign tx_done = (st == TX_STOP) && (baud_cnt == BIT_LAST);

endmodule

// File: rtl/uart_mem_dump_tx.sv
// Streams word_count 16-bit memory words starting at base_addr out over the
// UART, low byte first, one memory read per word in increasing address order.
module uart_mem_dump_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LATENCY  = 1
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              led_tx
);

  localparam logic [7:0] LAT_LAST = 8'(MEM_LATENCY - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_hold;
  logic [15:0]       remaining;
  logic [7:0]        lat_cnt;
  logic [DATA_W-1:0] word_reg;
  logic              byte_issued;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_done;

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_reg    <= '0;
      addr_hold   <= '0;
      remaining   <= '0;
      lat_cnt     <= '0;
      byte_issued <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_reg  <= base_addr;
            remaining <= word_count;
            state     <= (word_count == 16'd0) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FETCH: begin
          addr_hold <= addr_reg;
          lat_cnt   <= '0;
          state     <= ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          if (lat_cnt == LAT_LAST) state <= ST_SEND_LO;
          else lat_cnt <= lat_cnt + 8'd1;
        end
        ST_SEND_LO, ST_SEND_HI: begin
          if (tx_start) byte_issued <= 1'b1;
          if (tx_done) begin
            byte_issued <= 1'b0;
            state       <= (state == ST_SEND_LO) ? ST_SEND_HI : ST_NEXT;
          end
        end
        ST_NEXT: begin
          addr_reg  <= addr_reg + 1'b1;
          remaining <= remaining - 16'd1;
          state     <= (remaining == 16'd1) ? ST_FINISH : ST_FETCH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data is captured once the memory latency has elapsed in WAIT_RD.
  always_ff @(posedge clk_100) begin
    if (state == ST_WAIT_RD && lat_cnt == LAT_LAST)
      word_reg <= mem_rdata;
  end

  // The address goes out combinationally in FETCH so the read completes in
  // MEM_LATENCY cycles; afterwards the held copy keeps the port stable.
  assign mem_addr = (state == ST_FETCH) ? addr_reg : addr_hold;

  assign tx_start = ((state == ST_SEND_LO) || (state == ST_SEND_HI)) && !byte_issued && !tx_busy;
  assign tx_data  = (state == ST_SEND_HI) ? word_reg[15:8] : word_reg[7:0];

  assign busy   = (state != ST_IDLE) && (state != ST_FINISH);
  assign done   = (state == ST_FINISH);
  assign led_tx = busy;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_100 (clk_100),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

endmodule

// File: tb/tb_uart_mem_dump_tx.sv
// Bench for uart_mem_dump_tx: one instance at full baud timing, one at 4 clocks
// per bit, a shared memory model and a mid-bit UART decoder.
module tb_uart_mem_dump_tx;
  import uart_pkg::*;

  localparam int SLOW_C  = 868;
  localparam int FAST_C  = 4;
  localparam int MEM_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_s, start_f, sel;
  logic [15:0] base_addr, word_count;
  logic [15:0] addr_s, addr_f, rdata_s, rdata_f;
  logic        tx_s, tx_f, busy_s, busy_f, done_s, done_f, led_s, led_f;
  logic        mon_tx;

  uart_mem_dump_tx #(.CLKS_PER_BIT(SLOW_C), .ADDR_W(16), .DATA_W(16), .MEM_LATENCY(MEM_LAT)) dut_s (
    .clk_100(clk), .rst(rst), .start(start_s), .base_addr(base_addr), .word_count(word_count),
    .mem_addr(addr_s), .mem_rdata(rdata_s), .tx(tx_s), .busy(busy_s), .done(done_s), .led_tx(led_s));

  uart_mem_dump_tx #(.CLKS_PER_BIT(FAST_C), .ADDR_W(16), .DATA_W(16), .MEM_LATENCY(MEM_LAT)) dut_f (
    .clk_100(clk), .rst(rst), .start(start_f), .base_addr(base_addr), .word_count(word_count),
    .mem_addr(addr_f), .mem_rdata(rdata_f), .tx(tx_f), .busy(busy_f), .done(done_f), .led_tx(led_f));

  // Memory with one cycle of read latency from address to data.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    rdata_s <= mem[addr_s];
    rdata_f <= mem[addr_f];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign mon_tx = sel ? tx_s : tx_f;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Activity statistics, sampled on the falling edge.
  int done_cnt_s = 0, done_cnt_f = 0, done_cyc_s = 0, done_cyc_f = 0;
  int busy_cyc_s = 0, busy_cyc_f = 0, low_s = 0, low_f = 0, led_err = 0;
  logic [15:0] addr_q[$];
  initial begin
    logic [15:0] last_a = 16'h0;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (done_s) begin done_cnt_s++; done_cyc_s = cyc; end
      if (done_f) begin done_cnt_f++; done_cyc_f = cyc; end
      if (busy_s) busy_cyc_s++;
      if (busy_f) busy_cyc_f++;
      if (tx_s == 1'b0) low_s++;
      if (tx_f == 1'b0) low_f++;
      if (led_s !== busy_s || led_f !== busy_f) led_err++;
      a = sel ? addr_s : addr_f;
      if ((sel ? busy_s : busy_f) && a != last_a) begin
        addr_q.push_back(a);
        last_a = a;
      end
    end
  end

  // UART decoder: find the start bit, then sample each bit at its middle.
  logic [7:0] byte_q[$];
  int start_q[$];
  int frame_err = 0;
  initial begin
    int c, t0;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_tx == 1'b0 && !rst) begin
        t0 = cyc;
        c = sel ? SLOW_C : FAST_C;
        repeat (c / 2) @(negedge clk);
        if (mon_tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (c) @(negedge clk);
          b[i] = mon_tx;
        end
        repeat (c) @(negedge clk);
        if (mon_tx !== 1'b1) frame_err++;
        byte_q.push_back(b);
        start_q.push_back(t0);
      end
    end
  end

  task automatic kick(input logic [15:0] b, input logic [15:0] n);
    base_addr  = b;
    word_count = n;
    if (sel) start_s = 1'b1;
    else start_f = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_f = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    while (!(sel ? done_s : done_f) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, (sel ? done_s : done_f)}, 1);
  endtask

  task automatic chk_bytes(input string tag, input int base, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                           input int cnt);
    logic [7:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    chk({tag, "_nbytes"}, byte_q.size() - base, cnt);
    for (int i = 0; i < cnt; i++)
      if (byte_q.size() > base + i)
        chk($sformatf("%s_byte%0d", tag, i), {24'd0, byte_q[base + i]}, {24'd0, exp[i]});
  endtask

  initial begin
    int n, qb, ab, db, fe, s0, s1, s2;
    sel = 1'b0; rst = 1'b1; start_s = 1'b0; start_f = 1'b0;
    base_addr = '0; word_count = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // Reset values, then an idle line for 2000 cycles.
    repeat (5) @(negedge clk);
    chk("rst_tx", {30'd0, tx_s, tx_f}, 32'h3);
    chk("rst_busy_led", {28'd0, busy_s, busy_f, led_s, led_f}, 0);
    chk("rst_done", {30'd0, done_s, done_f}, 0);
    chk("rst_mem_addr", {addr_s, addr_f}, 0);
    rst = 1'b0;
    s0 = low_s + low_f; s1 = busy_cyc_s + busy_cyc_f; s2 = done_cnt_s + done_cnt_f;
    repeat (2000) @(negedge clk);
    chk("idle_tx_low", low_s + low_f - s0, 0);
    chk("idle_busy", busy_cyc_s + busy_cyc_f - s1, 0);
    chk("idle_done", done_cnt_s + done_cnt_f - s2, 0);

    // Single word at full baud timing.
    sel = 1'b1;
    mem[16'h0010] = 16'hA53C;
    qb = byte_q.size(); ab = addr_q.size(); db = done_cnt_s; fe = frame_err;
    kick(16'h0010, 16'd1);
    chk("t1_busy_after_start", {31'd0, busy_s}, 1);
    wait_done("t1", 3 * FRAME_BITS * SLOW_C, n);
    chk("t1_busy_at_done", {31'd0, busy_s}, 0);
    repeat (5) @(negedge clk);
    chk_bytes("t1", qb, 8'h3C, 8'hA5, 8'h00, 8'h00, 2);
    chk("t1_done_count", done_cnt_s - db, 1);
    chk("t1_frame_err", frame_err - fe, 0);
    chk("t1_naddr", addr_q.size() - ab, 1);
    if (addr_q.size() > ab) chk("t1_addr", {16'd0, addr_q[ab]}, 32'h0010);
    if (start_q.size() >= qb + 2) begin
      chk("t1_lo_to_hi", (start_q[qb+1] - start_q[qb] >= FRAME_BITS * SLOW_C) &&
                         (start_q[qb+1] - start_q[qb] <= FRAME_BITS * SLOW_C + 2), 1);
      chk("t1_hi_frame_len", (done_cyc_s - start_q[qb+1] >= FRAME_BITS * SLOW_C) &&
                             (done_cyc_s - start_q[qb+1] <= FRAME_BITS * SLOW_C + 3), 1);
    end

    // Two words crossing the address wrap.
    sel = 1'b0;
    mem[16'hFFFF] = 16'h1234;
    mem[16'h0000] = 16'hBEEF;
    qb = byte_q.size(); ab = addr_q.size(); db = done_cnt_f;
    kick(16'hFFFF, 16'd2);
    wait_done("t2", 400, n);
    chk("t2_busy_at_done", {31'd0, busy_f}, 0);
    repeat (5) @(negedge clk);
    chk_bytes("t2", qb, 8'h34, 8'h12, 8'hEF, 8'hBE, 4);
    chk("t2_done_count", done_cnt_f - db, 1);
    chk("t2_naddr", addr_q.size() - ab, 2);
    if (addr_q.size() >= ab + 2) begin
      chk("t2_addr0", {16'd0, addr_q[ab]}, 32'hFFFF);
      chk("t2_addr1", {16'd0, addr_q[ab+1]}, 32'h0000);
    end
    if (start_q.size() >= qb + 3)
      chk("t2_word_gap", (start_q[qb+2] - start_q[qb+1] - FRAME_BITS * FAST_C) <= MEM_LAT + 4, 1);

    // Zero word count.
    qb = byte_q.size(); db = done_cnt_f; s0 = low_f; s1 = busy_cyc_f;
    kick(16'h0200, 16'd0);
    wait_done("t3", 10, n);
    chk("t3_done_latency", n <= 1, 1);
    repeat (10) @(negedge clk);
    chk("t3_done_count", done_cnt_f - db, 1);
    chk("t3_busy_cycles", busy_cyc_f - s1 <= 1, 1);
    chk("t3_tx_low", low_f - s0, 0);
    chk("t3_nbytes", byte_q.size() - qb, 0);

    // Start while busy, and start coinciding with done.
    mem[16'h0010] = 16'hA53C;
    mem[16'h0011] = 16'h7E81;
    mem[16'h0100] = 16'hDEAD;
    mem[16'h0101] = 16'h0F0F;
    qb = byte_q.size(); ab = addr_q.size(); db = done_cnt_f;
    kick(16'h0010, 16'd2);
    repeat (20) @(negedge clk);
    kick(16'h0100, 16'd2);
    wait_done("t4", 400, n);
    base_addr = 16'h0100; word_count = 16'd1; start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    s1 = busy_cyc_f;
    repeat (50) @(negedge clk);
    chk("t4_no_restart", busy_cyc_f - s1, 0);
    chk_bytes("t4", qb, 8'h3C, 8'hA5, 8'h81, 8'h7E, 4);
    chk("t4_done_count", done_cnt_f - db, 1);
    chk("t4_naddr", addr_q.size() - ab, 2);
    if (addr_q.size() >= ab + 2) begin
      chk("t4_addr0", {16'd0, addr_q[ab]}, 32'h0010);
      chk("t4_addr1", {16'd0, addr_q[ab+1]}, 32'h0011);
    end

    // Reset during data bit 3 of the first byte, then a clean dump.
    kick(16'h0010, 16'd2);
    n = 0;
    while (tx_f !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_frame_started", {31'd0, tx_f}, 0);
    repeat (4 * FAST_C + 1) @(negedge clk);
    db = done_cnt_f;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tx_after_rst", {31'd0, tx_f}, 1);
    chk("t5_busy_after_rst", {31'd0, busy_f}, 0);
    chk("t5_done_after_rst", {31'd0, done_f}, 0);
    rst = 1'b0;
    s0 = low_f; s1 = busy_cyc_f;
    repeat (200) @(negedge clk);
    chk("t5_tx_stays_high", low_f - s0, 0);
    chk("t5_busy_stays_low", busy_cyc_f - s1, 0);
    chk("t5_no_done", done_cnt_f - db, 0);
    qb = byte_q.size(); db = done_cnt_f;
    kick(16'h0010, 16'd2);
    wait_done("t5", 400, n);
    repeat (5) @(negedge clk);
    chk_bytes("t5", qb, 8'h3C, 8'hA5, 8'h81, 8'h7E, 4);
    chk("t5_done_count", done_cnt_f - db, 1);

    chk("led_tracks_busy", led_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
